// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared widths, FSM state codes and bus payload types for
// the two-requester data-memory arbiter.
// Optional build macro: ARB_FIXED_PRIO_EN (requester 0 always wins ties).
package dm_arbiter_pkg;

  localparam int unsigned AW  = 10;  // word address width (byte address [11:2])
  localparam int unsigned DW  = 32;  // data width
  localparam int unsigned BSW = 2;   // byte-select width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // One requester's access fields
  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic           bmode;
    logic [BSW-1:0] bsel;
  } req_t;

  // Memory control bundle driven during the access cycle
  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  din;
    logic           we;
    logic           bmode;
    logic [BSW-1:0] bsel;
  } dm_cmd_t;

  function automatic dm_cmd_t to_cmd(input req_t r);
    return '{addr: r.addr, din: r.wdata, we: r.we, bmode: r.bmode, bsel: r.bsel};
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester-side and memory-side signals of the arbiter.
//   r0_*/r1_* : request fields in, ack/rdata out (per requester)
//   dm_*      : memory controls out, dm_dout in
//   busy, gnt_id : status out
// Modport slave is the arbiter view; master is the requester/memory view.
interface dm_arbiter_if;
  import dm_arbiter_pkg::*;

  logic           r0_req, r0_we, r0_bmode, r0_ack;
  logic [AW-1:0]  r0_addr;
  logic [DW-1:0]  r0_wdata, r0_rdata;
  logic [BSW-1:0] r0_bsel;

  logic           r1_req, r1_we, r1_bmode, r1_ack;
  logic [AW-1:0]  r1_addr;
  logic [DW-1:0]  r1_wdata, r1_rdata;
  logic [BSW-1:0] r1_bsel;

  logic [AW-1:0]  dm_addr;
  logic [DW-1:0]  dm_din, dm_dout;
  logic           dm_we, dm_bmode;
  logic [BSW-1:0] dm_bsel;

  logic           busy, gnt_id;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_bmode, r0_bsel,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_bmode, r1_bsel,
    input  dm_dout,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output dm_addr, dm_din, dm_we, dm_bmode, dm_bsel,
    output busy, gnt_id
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_bmode, r0_bsel,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_bmode, r1_bsel,
    output dm_dout,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  dm_addr, dm_din, dm_we, dm_bmode, dm_bsel,
    input  busy, gnt_id
  );

endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// dm_arbiter_rr_pick: combinational 2-way picker.
//   i_req     : request vector {r1, r0}
//   i_ptr     : favoured requester on a tie (absent under ARB_FIXED_PRIO_EN)
//   o_gnt_c   : picked requester id
//   o_valid_c : any request present
// Under ARB_FIXED_PRIO_EN requester 0 always wins a tie.
module dm_arbiter_rr_pick (
  input  logic [1:0] i_req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic       i_ptr,
`endif
  output logic       o_gnt_c,
  output logic       o_valid_c
);

  assign o_valid_c = |i_req;

`ifdef ARB_FIXED_PRIO_EN
  assign o_gnt_c = ~i_req[0];
`else
  // Tie goes to the pointer; otherwise the lone requester
  assign o_gnt_c = (&i_req) ? i_ptr : i_req[1];
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU load/store
// path (requester 0) and the debug/DMA loader (requester 1).
// Each access runs IDLE -> ACC -> ACK; ties alternate round-robin unless
// ARB_FIXED_PRIO_EN is defined (requester 0 then always wins).
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   io_bus : dm_arbiter_if.slave (requester handshakes, memory controls, status)
module dm_arbiter
  import dm_arbiter_pkg::*;
(
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave io_bus
);

  state_e        r_state, w_state_nxt;
  logic          r_gnt_id, w_gnt_nxt;
  dm_cmd_t       r_dm, w_dm_nxt;
  logic          r_ack0, r_ack1, w_ack0_nxt, w_ack1_nxt;
  logic [DW-1:0] r_rdata0, r_rdata1, w_rdata0_nxt, w_rdata1_nxt;
  logic          r_busy, w_busy_nxt;
  req_t          w_req0, w_req1;
  logic          w_pick_gnt, w_pick_valid;

  assign w_req0 = '{we: io_bus.r0_we, addr: io_bus.r0_addr, wdata: io_bus.r0_wdata,
                    bmode: io_bus.r0_bmode, bsel: io_bus.r0_bsel};
  assign w_req1 = '{we: io_bus.r1_we, addr: io_bus.r1_addr, wdata: io_bus.r1_wdata,
                    bmode: io_bus.r1_bmode, bsel: io_bus.r1_bsel};

`ifdef ARB_FIXED_PRIO_EN
  dm_arbiter_rr_pick u_pick (
    .i_req     ({io_bus.r1_req, io_bus.r0_req}),
    .o_gnt_c   (w_pick_gnt),
    .o_valid_c (w_pick_valid)
  );
`else
  logic r_rr_ptr, w_rr_nxt;

  dm_arbiter_rr_pick u_pick (
    .i_req     ({io_bus.r1_req, io_bus.r0_req}),
    .i_ptr     (r_rr_ptr),
    .o_gnt_c   (w_pick_gnt),
    .o_valid_c (w_pick_valid)
  );

  // Tie-break pointer: favours the requester not served last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rr_ptr <= 1'b0;
    else      r_rr_ptr <= w_rr_nxt;
  end
`endif

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_gnt_id <= 1'b0;
      r_dm     <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt_id <= w_gnt_nxt;
      r_dm     <= w_dm_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next state; memory controls are loaded on entry to ACC and cleared on exit
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt_id;
    w_dm_nxt     = '0;
    w_ack0_nxt   = 1'b0;
    w_ack1_nxt   = 1'b0;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
`ifndef ARB_FIXED_PRIO_EN
    w_rr_nxt     = r_rr_ptr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick_gnt;
          w_state_nxt = ST_ACC;
          w_dm_nxt    = w_pick_gnt ? to_cmd(w_req1) : to_cmd(w_req0);
        end
      end
      ST_ACC: begin
        w_state_nxt = ST_ACK;
        w_ack0_nxt  = ~r_gnt_id;
        w_ack1_nxt  = r_gnt_id;
        // Read data is captured only into the granted requester's register
        if (!r_dm.we) begin
          if (r_gnt_id) w_rdata1_nxt = io_bus.dm_dout;
          else          w_rdata0_nxt = io_bus.dm_dout;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
`ifndef ARB_FIXED_PRIO_EN
        w_rr_nxt    = ~r_gnt_id;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign io_bus.dm_addr  = r_dm.addr;
  assign io_bus.dm_din   = r_dm.din;
  assign io_bus.dm_we    = r_dm.we;
  assign io_bus.dm_bmode = r_dm.bmode;
  assign io_bus.dm_bsel  = r_dm.bsel;
  assign io_bus.r0_ack   = r_ack0;
  assign io_bus.r1_ack   = r_ack1;
  assign io_bus.r0_rdata = r_rdata0;
  assign io_bus.r1_rdata = r_rdata1;
  assign io_bus.busy     = r_busy;
  assign io_bus.gnt_id   = r_gnt_id;

endmodule
